// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg
// Shared types for the register-file port arbiter.
//   rf_pointer_width : register address width used by the command struct
//   req_id_t         : requester id (0 = CPU core, 1 = debug/loader)
//   arb_state_t      : arbitration FSM states
//   cmd_t            : one accepted command as it travels down the pipeline
package regfile_arb_pkg;

    localparam int rf_pointer_width = 3;

    typedef logic req_id_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                        write;
        logic                        imm;
        logic [rf_pointer_width-1:0] addr;
        logic [7:0]                  data;
        req_id_t                     id;
    } cmd_t;

endpackage

// File: rtl/regfile_port_arbiter_rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin chooser.
//   valid      : requests from the two requesters
//   mask       : eligibility mask; a request whose mask bit is 0 is ignored
//   last_grant : id granted most recently; the other id wins a tie
//   grant      : one-hot grant (all zero when nothing eligible)
//   grant_id   : index of the granted requester (0 when nothing granted)
module rr_pick2
    import regfile_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic [1:0] mask,
    input  req_id_t    last_grant,
    output logic [1:0] grant,
    output req_id_t    grant_id
);

    logic [1:0] eligible;

    assign eligible = valid & mask;

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        case (eligible)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                grant_id = ~last_grant;
                grant    = last_grant ? 2'b01 : 2'b10;
            end
            default: begin
                grant    = 2'b00;
                grant_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares the single-port register file between the CPU core (requester 0)
// and the debug/loader port (requester 1). Round-robin arbitration with an
// optional lock for atomic read-modify-write, followed by a two-stage
// in-order pipeline: stage 1 drives the register file, stage 2 returns
// read data tagged with the requester id.
//   clock, reset       : system clock, asynchronous active-high reset
//   req_*              : per-requester command inputs, req_ready per requester
//   rsp_valid/id/data  : read response, one-cycle pulse, 2 cycles after accept
//   rf_*               : register file interface (owned entirely by this block)
//
// pointer_width must match regfile_arb_pkg::rf_pointer_width, which sizes the
// address field of the command struct.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ARB    | round-robin between valid requesters, tie goes to ~last_grant
// LOCKED | only last_grant (the lock owner) may be accepted
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int pointer_width = rf_pointer_width
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0]                    req_write,
    input  logic [1:0]                    req_lock,
    input  logic [1:0]                    req_imm,
    input  logic [1:0][pointer_width-1:0] req_addr,
    input  logic [1:0][7:0]               req_data,
    output logic                          rsp_valid,
    output logic                          rsp_id,
    output logic [7:0]                    rsp_data,
    output logic                          rf_write_enable,
    output logic [pointer_width-1:0]      rf_address,
    output logic [7:0]                    rf_data_in,
    output logic                          rf_is_immediate,
    input  logic [7:0]                    rf_data_out
);

    arb_state_t state;
    req_id_t    last_grant;
    logic [1:0] mask;
    logic [1:0] grant;
    req_id_t    grant_id;
    logic       accept;
    cmd_t       sel;
    logic       s1_read;
    req_id_t    s1_id;

    // While locked, last_grant is the owner, so it doubles as the lock owner.
    assign mask = (state == LOCKED) ? (last_grant ? 2'b10 : 2'b01) : 2'b11;

    rr_pick2 u_pick (
        .valid      (req_valid),
        .mask       (mask),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign req_ready = reset ? 2'b00 : grant;
    assign accept    = |req_ready;

    always_comb begin
        sel       = '0;
        sel.write = req_write[grant_id];
        sel.imm   = req_imm[grant_id];
        sel.addr  = req_addr[grant_id];
        sel.data  = req_data[grant_id];
        sel.id    = grant_id;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ARB: begin
                    if (accept) begin
                        last_grant <= grant_id;
                        state      <= req_lock[grant_id] ? LOCKED : ARB;
                    end
                end
                LOCKED: begin
                    if (accept && !req_lock[grant_id]) begin
                        state <= ARB;
                    end
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

    // Stage 1: registered register-file drive. Address/data/immediate hold
    // when idle; only the write enable is forced low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_write_enable <= 1'b0;
            rf_address      <= '0;
            rf_data_in      <= '0;
            rf_is_immediate <= 1'b0;
            s1_read         <= 1'b0;
            s1_id           <= 1'b0;
        end else begin
            rf_write_enable <= accept && sel.write;
            s1_read         <= accept && !sel.write;
            if (accept) begin
                rf_address      <= sel.addr;
                rf_data_in      <= sel.data;
                rf_is_immediate <= sel.imm;
                s1_id           <= sel.id;
            end
        end
    end

    // Stage 2: capture read data at the edge that ends the stage-1 cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= s1_read;
            if (s1_read) begin
                rsp_id   <= s1_id;
                rsp_data <= rf_data_out;
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

    logic            clock;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_write;
    logic [1:0]      req_lock;
    logic [1:0]      req_imm;
    logic [1:0][2:0] req_addr;
    logic [1:0][7:0] req_data;
    logic            rsp_valid;
    logic            rsp_id;
    logic [7:0]      rsp_data;
    logic            rf_write_enable;
    logic [2:0]      rf_address;
    logic [7:0]      rf_data_in;
    logic            rf_is_immediate;
    logic [7:0]      rf_data_out;

    regfile_port_arbiter #(.pointer_width(3)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_lock        (req_lock),
        .req_imm         (req_imm),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .rf_write_enable (rf_write_enable),
        .rf_address      (rf_address),
        .rf_data_in      (rf_data_in),
        .rf_is_immediate (rf_is_immediate),
        .rf_data_out     (rf_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Register file model: initial contents 0x10+i, immediate reads return 0xC0|addr.
    logic [7:0] mem [8];
    bit loaded = 1'b0;
    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h10 + 8'(i);
            loaded <= 1'b1;
        end else if (rf_write_enable) begin
            mem[rf_address] <= rf_data_in;
        end
    end
    assign rf_data_out = rf_is_immediate ? (8'hC0 | {5'b0, rf_address}) : mem[rf_address];

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [1:0] lk,
                         input logic [1:0] im, input logic [2:0] a0, input logic [2:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] exp_rdy, input logic [7:0] exp_data,
                         input bit push, input string name);
        exp_t e;
        @(negedge clock);
        req_valid   = v;
        req_write   = w;
        req_lock    = lk;
        req_imm     = im;
        req_addr[0] = a0;
        req_addr[1] = a1;
        req_data[0] = d0;
        req_data[1] = d1;
        #1;
        chk(name, {30'b0, req_ready}, {30'b0, exp_rdy});
        if (push) begin
            e.id   = exp_rdy[1];
            e.data = exp_data;
            e.cyc  = cyc + 2;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0, "idle_ready");
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ready"}, {30'b0, req_ready}, 32'd0);
        chk({name, "_we"}, {31'b0, rf_write_enable}, 32'd0);
        chk({name, "_addr"}, {29'b0, rf_address}, 32'd0);
        chk({name, "_din"}, {24'b0, rf_data_in}, 32'd0);
        chk({name, "_imm"}, {31'b0, rf_is_immediate}, 32'd0);
        chk({name, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({name, "_rsp_id"}, {31'b0, rsp_id}, 32'd0);
        chk({name, "_rsp_data"}, {24'b0, rsp_data}, 32'd0);
    endtask

    // Response monitor: every rsp_valid pulse must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected got id %0d data %0h expected no response (cycle %0d)",
                             rsp_id, rsp_data, cyc);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
                    chk("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_lock  = 2'b00;
        req_imm   = 2'b00;
        req_addr  = '0;
        req_data  = '0;

        // Power-on reset
        @(negedge clock);
        @(negedge clock);
        req_valid = 2'b11;
        #1;
        chk_all_zero("por");
        @(negedge clock);
        reset     = 1'b0;
        req_valid = 2'b00;

        // Contention: req0 reads r1, req1 reads r2, grants alternate from 0
        drive(2'b11, 2'b00, 2'b00, 2'b00, 3'd1, 3'd2, 8'h0, 8'h0, 2'b01, 8'h11, 1'b1, "cont0");
        drive(2'b11, 2'b00, 2'b00, 2'b00, 3'd1, 3'd2, 8'h0, 8'h0, 2'b10, 8'h12, 1'b1, "cont1");
        drive(2'b11, 2'b00, 2'b00, 2'b00, 3'd1, 3'd2, 8'h0, 8'h0, 2'b01, 8'h11, 1'b1, "cont2");
        drive(2'b11, 2'b00, 2'b00, 2'b00, 3'd1, 3'd2, 8'h0, 8'h0, 2'b10, 8'h12, 1'b1, "cont3");

        // Single requester: write r3=0x5A, then read it back
        drive(2'b01, 2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 8'h5A, 8'h0, 2'b01, 8'h00, 1'b0, "wr_r3");
        drive(2'b01, 2'b00, 2'b00, 2'b00, 3'd3, 3'd0, 8'h00, 8'h0, 2'b01, 8'h5A, 1'b1, "rd_r3");
        chk("wr_r3_we", {31'b0, rf_write_enable}, 32'd1);
        chk("wr_r3_addr", {29'b0, rf_address}, 32'd3);
        chk("wr_r3_din", {24'b0, rf_data_in}, 32'h5A);
        idle(1);
        chk("rd_r3_we_low", {31'b0, rf_write_enable}, 32'd0);

        // Lock: req1 owns the port across two locked reads and the unlock write
        drive(2'b11, 2'b00, 2'b10, 2'b00, 3'd0, 3'd7, 8'h0, 8'h00, 2'b10, 8'h17, 1'b1, "lock_rd_a");
        drive(2'b11, 2'b00, 2'b10, 2'b00, 3'd0, 3'd7, 8'h0, 8'h00, 2'b10, 8'h17, 1'b1, "lock_rd_b");
        drive(2'b11, 2'b10, 2'b00, 2'b00, 3'd0, 3'd7, 8'h0, 8'h11, 2'b10, 8'h00, 1'b0, "unlock_wr");
        drive(2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'd7, 8'h0, 8'h00, 2'b01, 8'h10, 1'b1, "after_unlock0");
        chk("unlock_wr_we", {31'b0, rf_write_enable}, 32'd1);
        chk("unlock_wr_din", {24'b0, rf_data_in}, 32'h11);
        drive(2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'd7, 8'h0, 8'h00, 2'b10, 8'h11, 1'b1, "after_unlock1");
        idle(1);

        // Immediate read of addr 5
        drive(2'b01, 2'b00, 2'b00, 2'b01, 3'd5, 3'd0, 8'h0, 8'h0, 2'b01, 8'hC5, 1'b1, "imm_rd");
        idle(1);
        chk("imm_flag", {31'b0, rf_is_immediate}, 32'd1);
        chk("imm_addr", {29'b0, rf_address}, 32'd5);
        idle(2);

        // Reset with a read in stage 1: outputs clear, no response follows
        drive(2'b01, 2'b00, 2'b00, 2'b00, 3'd2, 3'd0, 8'h0, 8'h0, 2'b01, 8'h00, 1'b0, "rst_rd");
        @(negedge clock);
        reset     = 1'b1;
        req_valid = 2'b11;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clock);
        reset     = 1'b0;
        req_valid = 2'b00;
        idle(3);
        drive(2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'd1, 8'h0, 8'h0, 2'b01, 8'h10, 1'b1, "post_rst_first");

        // Reset with a write in stage 1: the write never reaches the register file
        drive(2'b01, 2'b01, 2'b00, 2'b00, 3'd4, 3'd0, 8'hEE, 8'h0, 2'b01, 8'h00, 1'b0, "wr_r4");
        @(negedge clock);
        reset     = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("rst_wr_we", {31'b0, rf_write_enable}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(2'b01, 2'b00, 2'b00, 2'b00, 3'd4, 3'd0, 8'h0, 8'h0, 2'b01, 8'h14, 1'b1, "rd_r4");
        idle(4);

        chk("rsp_queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Shares the single-port `register_file` between two requesters: requester 0 is the CPU core and requester 1 is the debug/loader port. The block uses round-robin arbitration with valid/ready handshakes, a lock for atomic read-modify-write, and a registered two-stage pipeline in front of the register file. Read responses carry the requester id. It sits between the core/loader and the register file instance, and owns every register file input.

## Interface
Parameters:
- `pointer_width`, default 3: register address width; the register file has 2**pointer_width entries.

Ports (clock and reset first):
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  [1:0]  requester i presents a command.
- `req_ready`  out  [1:0]  requester i's command is accepted this cycle; at most one bit is high.
- `req_write`  in  [1:0]  1 = write, 0 = read.
- `req_lock`  in  [1:0]  keep ownership after this command.
- `req_imm`  in  [1:0]  forwarded to `is_immediate`.
- `req_addr`  in  [1:0][pointer_width-1:0]  register address.
- `req_data`  in  [1:0][7:0]  write data.
- `rsp_valid`  out  1  read data valid, one-cycle pulse.
- `rsp_id`  out  1  requester that issued the read.
- `rsp_data`  out  8  read data.
- `rf_write_enable`  out  1  to register file.
- `rf_address`  out  pointer_width  to register file.
- `rf_data_in`  out  8  to register file.
- `rf_is_immediate`  out  1  to register file.
- `rf_data_out`  in  8  from register file.

## Operation
- A handshake occurs when `req_valid[i] && req_ready[i]`; that is the accept cycle N.
- `req_ready` is combinational from `req_valid`, the state and `last_grant`; it never depends on `rsp_*`.
- Arbitration state machine:
  - ARB: if exactly one requester is valid, grant it. If both are valid, grant `~last_grant`. On a grant, `last_grant` is set to the granted id.
  - Transition to LOCKED(owner) when the accepted command has `req_lock=1`.
  - LOCKED: only the owner can get `req_ready`, even if the other requester is valid.
  - The owner's accepted command with `req_lock=0` returns the state to ARB the next cycle. In LOCKED, `last_grant` stays equal to the owner.
- A write produces no response. A read produces exactly one response; `rsp_id` is the issuing requester.
- Commands execute in accept order. A read issued after an accepted write to the same address returns the new data, with no bypassing needed because of the in-order pipeline.
- When no command is accepted, stage 1 drives `rf_write_enable=0`. The address and data outputs then hold their previous values.

## Timing
- Cycle N: accept; the command is registered into stage 1.
- Cycle N+1: stage 1 drives the `rf_*` ports. The write commits at the edge ending N+1. For a read, `rf_data_out` is sampled at that same edge into stage 2.
- Cycle N+2: `rsp_valid=1`, with `rsp_data` and `rsp_id` from stage 2. Read latency is 2 cycles.
- Throughput is one command per cycle. Back-to-back grants to the same requester are allowed when the other requester is idle.
- Reset values:
  - `rf_write_enable=0`, `rf_address=0`, `rf_data_in=0`, `rf_is_immediate=0`.
  - `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`.
  - `req_ready=0` while reset is high.
  - State ARB, `last_grant=1`, so requester 0 wins the first contention.
- Reset mid-operation: in-flight stage 1 and stage 2 contents are discarded and no response is produced. An un-committed write in stage 1 is dropped.
- Both valid in LOCKED: only the owner is served, with no round-robin update. The non-owner waits indefinitely; ensuring the lock is released is the owner's responsibility.

## Structure
- Package `regfile_arb_pkg` holds:
  - `typedef logic req_id_t`.
  - `typedef enum {ARB, LOCKED} arb_state_t`.
  - `typedef struct packed {write, imm, addr, data, id}` command type. `addr` width comes from `pointer_width`; define it in the package with default 3.
- One natural sub-module: `rr_pick2`, a combinational 2-way round-robin chooser with a mask input (used for the lock).
- Pipeline registers, the lock FSM and `last_grant` stay in the top module.

## Test plan
- Reset: assert `reset` mid-stream → all outputs are 0 immediately and no `rsp_valid` follows. After release, both valid → requester 0 is granted first.
- Single requester: requester 0 writes 0x5A to r3 in cycle N, then reads r3 in N+1 → `rf_write_enable` high in N+1; `rsp_valid` in N+3 with `rsp_data=0x5A` and `rsp_id=0`.
- Contention: both requesters hold reads of r1 and r2 for 4 cycles → grants alternate 0,1,0,1. Responses return in the same order, each 2 cycles after its accept.
- Lock: requester 1 reads r7 with `req_lock=1`, then writes r7=0x11 with `req_lock=0`, while requester 0 stays valid throughout → requester 0 gets no `req_ready` until the cycle after the unlock write is accepted.
- Immediate: requester 0 reads with `req_imm=1` and addr=5 → `rf_is_immediate=1` and `rf_address=5` in N+1; `rsp_data` equals `rf_data_out` sampled at the end of N+1.
- Reset mid-operation: assert reset in the cycle after a write is accepted → the register file sees no write-enable and the register retains its old value.
